morse_captura: RTL and testbench
================================

MORSE_CAPTURA -- requirements
Module: morse_captura

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per time-base tick (1 ms at 50 MHz).
REQ-002 Parameter DEBOUNCE, default 10, ticks an input level must be stable before it is accepted.
REQ-003 Parameter DOT_MAX, default 200, longest press in ticks classified as short.
REQ-004 Parameter GAP, default 600, release time in ticks that ends a character.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 key  input  1  raw telegraph key, 1 = pressed, asynchronous to clk.
REQ-008 ack  input  1  consumer acknowledge of a completed character.
REQ-009 morse  output  10  captured character: 5 symbols x 2 bits, symbol 0 in [1:0]; 00 none, 01 short, 10 long.
REQ-010 nsym  output  3  number of symbols captured, 0..5.
REQ-011 valid  output  1  morse/nsym/overflow hold a completed character.
REQ-012 overflow  output  1  more than 5 symbols were keyed in this character.
REQ-013 short, long  output  1 each  one-cycle pulse when a symbol is classified, for sound echo.
REQ-014 busy  output  1  a character is being assembled.

Function
REQ-015 key SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 A free-running tick counter SHALL produce a one-cycle tick every TICK_DIV clk cycles, counting from reset release.
REQ-017 The debounced level SHALL change only after the synchronized level has differed from it on DEBOUNCE consecutive ticks; any bounce restarts the count.
REQ-018 FSM states: IDLE, PRESS, GAPW, DONE; reset state IDLE.
REQ-019 IDLE -> PRESS on debounced rise; symbol buffer, nsym and overflow cleared on this transition.
REQ-020 PRESS: press counter increments per tick, saturating at DOT_MAX+1.
REQ-021 PRESS -> GAPW on debounced fall; in that same cycle, count <= DOT_MAX classifies short, otherwise long.
REQ-022 The classified symbol SHALL be written at index nsym and nsym incremented, visible the cycle after the fall; short or long pulses high in that cycle.
REQ-023 If nsym = 5 at classification, the symbol SHALL be discarded, nsym held at 5, overflow set; the short/long pulse still fires.
REQ-024 GAPW: gap counter increments per tick; a debounced rise returns to PRESS with the gap counter cleared.
REQ-025 GAPW -> DONE when the gap counter reaches GAP; valid SHALL be 1 from the next cycle.
REQ-026 DONE: morse, nsym and overflow stable; key activity ignored, no pulses.
REQ-027 ack while valid = 1 SHALL clear valid next cycle, return to IDLE and leave morse/nsym readable until the next capture starts.
REQ-028 ack while valid = 0 SHALL have no effect.
REQ-029 A key still held at ack SHALL NOT start a capture; capture requires a fresh debounced rise seen in IDLE.
REQ-030 busy = 1 in PRESS and GAPW only.
REQ-031 Unused symbol slots SHALL read 00.

Reset
REQ-032 Reset asserted at any time, including mid-press or in DONE, SHALL force IDLE immediately; the character in progress is lost.
REQ-033 Reset values: morse = 0, nsym = 0, valid = 0, overflow = 0, short = 0, long = 0, busy = 0, all counters and synchronizer flops 0, debounced level 0.

Verification (TICK_DIV=4, DEBOUNCE=2, DOT_MAX=5, GAP=10)
REQ-034 Press 12 cycles, release -> one short pulse, then after GAP: valid = 1, morse = 10'b00_00_00_00_01, nsym = 1.
REQ-035 Press long (60 cycles), gap 20, press short, release -> morse = 10'b00_00_00_01_10, nsym = 2, overflow = 0.
REQ-036 Six short presses, then gap -> nsym = 5, morse = 10'b01_01_01_01_01, overflow = 1, six short pulses total.
REQ-037 key toggling every 3 cycles for 40 cycles (bounce), then steady 0 -> no pulse, busy = 0, valid = 0.
REQ-038 Presses while valid = 1 -> morse unchanged; ack -> valid = 0 next cycle; new press then captures a fresh character.
REQ-039 Reset during PRESS -> all outputs 0 at once; after release, a single short press yields nsym = 1.

Source files
------------

// File: rtl/morse_captura_if.sv
// Bundle of key/acknowledge inputs and captured-character outputs of the
// Morse key capture block. The capture block is the slave; whoever drives
// the key and consumes characters is the master.
interface morse_captura_if;
  logic       key;
  logic       ack;
  logic [9:0] morse;
  logic [2:0] nsym;
  logic       valid;
  logic       overflow;
  logic       short;
  logic       long;
  logic       busy;

  modport master (
    output key,
    output ack,
    input  morse,
    input  nsym,
    input  valid,
    input  overflow,
    input  short,
    input  long,
    input  busy
  );

  modport slave (
    input  key,
    input  ack,
    output morse,
    output nsym,
    output valid,
    output overflow,
    output short,
    output long,
    output busy
  );
endinterface

// File: rtl/morse_captura.sv
// Telegraph key capture: synchronizes and debounces a raw key, times each
// press against a tick time base, classifies it as short or long, packs up
// to five symbols into a character and hands it off with valid/ack.
module morse_captura #(
  parameter int TICK_DIV = 50000,
  parameter int DEBOUNCE = 10,
  parameter int DOT_MAX  = 200,
  parameter int GAP      = 600
) (
  input  logic            clk,
  input  logic            reset,
  morse_captura_if.slave  bus
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int PRESS_W = $clog2(DOT_MAX + 2);
  localparam int GAP_W   = $clog2(GAP + 1);
  localparam int MAX_SYM = 5;

  typedef enum logic [1:0] {IDLE, PRESS, GAPW, DONE} state_t;

  state_t state;
  state_t state_n;

  // key synchronizer
  logic key_s1;
  logic key_s2;

  // time base
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  // debouncer
  logic             deb;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_flip;
  logic             deb_rise;
  logic             deb_fall;

  // character assembly
  logic [PRESS_W-1:0] press_cnt;
  logic [PRESS_W-1:0] press_n;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_n;
  logic [9:0]         morse_r;
  logic [9:0]         morse_n;
  logic [2:0]         nsym_r;
  logic [2:0]         nsym_n;
  logic               ovf_r;
  logic               ovf_n;
  logic               valid_r;
  logic               valid_n;
  logic               short_r;
  logic               short_n;
  logic               long_r;
  logic               long_n;
  logic               is_short;
  logic [1:0]         sym;

  // Two-flop synchronizer for the asynchronous key input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      key_s1 <= bus.key;
      key_s2 <= key_s1;
    end
  end

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Free-running divider: one tick every TICK_DIV cycles after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // The accepted level flips on the tick that completes DEBOUNCE consecutive
  // disagreeing ticks; rise/fall pulses are valid in that same cycle.
  assign deb_flip = tick && (key_s2 != deb) && (deb_cnt == DEB_W'(DEBOUNCE - 1));
  assign deb_rise = deb_flip && key_s2;
  assign deb_fall = deb_flip && !key_s2;

  // Debounce counter: any cycle where the synchronized key agrees with the
  // accepted level restarts the count, so short bounces never accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (key_s2 == deb) begin
      deb_cnt <= '0;
    end else if (tick) begin
      if (deb_flip) begin
        deb     <= key_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next values of the character registers.
  always_comb begin
    state_n  = state;
    press_n  = press_cnt;
    gap_n    = gap_cnt;
    morse_n  = morse_r;
    nsym_n   = nsym_r;
    ovf_n    = ovf_r;
    valid_n  = valid_r;
    short_n  = 1'b0;
    long_n   = 1'b0;
    is_short = 1'b0;
    sym      = 2'b00;

    case (state)
      IDLE: begin
        // Only a fresh rise starts a capture; a key still held from before
        // the acknowledge has no edge here and is ignored.
        if (deb_rise) begin
          state_n = PRESS;
          morse_n = '0;
          nsym_n  = '0;
          ovf_n   = 1'b0;
          press_n = '0;
        end
      end

      PRESS: begin
        if (deb_fall) begin
          // Classify on the count reached before this tick.
          is_short = (press_cnt <= PRESS_W'(DOT_MAX));
          short_n  = is_short;
          long_n   = !is_short;
          sym      = is_short ? 2'b01 : 2'b10;
          if (nsym_r == 3'(MAX_SYM)) begin
            ovf_n = 1'b1;
          end else begin
            for (int i = 0; i < MAX_SYM; i++) begin
              if (nsym_r == 3'(i)) begin
                morse_n[2*i +: 2] = sym;
              end
            end
            nsym_n = nsym_r + 3'd1;
          end
          gap_n   = '0;
          state_n = GAPW;
        end else if (tick && (press_cnt != PRESS_W'(DOT_MAX + 1))) begin
          press_n = press_cnt + 1'b1;
        end
      end

      GAPW: begin
        if (deb_rise) begin
          state_n = PRESS;
          gap_n   = '0;
          press_n = '0;
        end else if (gap_cnt == GAP_W'(GAP)) begin
          state_n = DONE;
          valid_n = 1'b1;
        end else if (tick) begin
          gap_n = gap_cnt + 1'b1;
        end
      end

      DONE: begin
        // Character held; key activity ignored until the consumer takes it.
        if (bus.ack) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Character, counter and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_cnt <= '0;
      gap_cnt   <= '0;
      morse_r   <= '0;
      nsym_r    <= '0;
      ovf_r     <= 1'b0;
      valid_r   <= 1'b0;
      short_r   <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      press_cnt <= press_n;
      gap_cnt   <= gap_n;
      morse_r   <= morse_n;
      nsym_r    <= nsym_n;
      ovf_r     <= ovf_n;
      valid_r   <= valid_n;
      short_r   <= short_n;
      long_r    <= long_n;
    end
  end

  assign bus.morse    = morse_r;
  assign bus.nsym     = nsym_r;
  assign bus.overflow = ovf_r;
  assign bus.valid    = valid_r;
  assign bus.short    = short_r;
  assign bus.long     = long_r;
  assign bus.busy     = (state == PRESS) || (state == GAPW);

endmodule

// File: tb/tb_morse_captura.sv
// Bench for morse_captura with a small time base; expected characters are
// queued by the stimulus and checked by a monitor when valid rises.
module tb_morse_captura;

  localparam int TICK_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int DOT_MAX  = 5;
  localparam int GAP      = 10;

  typedef struct {
    logic [9:0] morse;
    logic [2:0] nsym;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   n_short     = 0;
  int   n_long      = 0;
  logic valid_q     = 1'b0;

  morse_captura_if bus ();

  morse_captura #(
    .TICK_DIV (TICK_DIV),
    .DEBOUNCE (DEBOUNCE),
    .DOT_MAX  (DOT_MAX),
    .GAP      (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int on, input int off);
    bus.key = 1'b1;
    cyc(on);
    bus.key = 1'b0;
    cyc(off);
  endtask

  task automatic expect_char(input logic [9:0] m, input logic [2:0] n, input logic o);
    exp_t e;
    e.morse = m;
    e.nsym  = n;
    e.ovf   = o;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!bus.valid && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, bus.valid, 1);
    cyc(1);
  endtask

  task automatic do_ack(input string name);
    bus.ack = 1'b1;
    cyc(1);
    bus.ack = 1'b0;
    check(name, bus.valid, 0);
  endtask

  // Monitor: counts echo pulses and checks each completed character.
  always @(negedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.valid;
      if (bus.short) n_short <= n_short + 1;
      if (bus.long)  n_long  <= n_long + 1;
      if (bus.valid && !valid_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected char", 1, 0);
        end else begin
          check("char morse", 32'(bus.morse), 32'(exp_q[0].morse));
          check("char nsym", 32'(bus.nsym), 32'(exp_q[0].nsym));
          check("char overflow", 32'(bus.overflow), 32'(exp_q[0].ovf));
          exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int l0;

    bus.key = 1'b0;
    bus.ack = 1'b0;
    reset   = 1'b1;
    cyc(3);
    check("reset morse", bus.morse, 0);
    check("reset nsym", bus.nsym, 0);
    check("reset valid", bus.valid, 0);
    check("reset overflow", bus.overflow, 0);
    check("reset short", bus.short, 0);
    check("reset long", bus.long, 0);
    check("reset busy", bus.busy, 0);
    reset = 1'b0;
    cyc(5);

    // ack with nothing pending does nothing
    bus.ack = 1'b1;
    cyc(1);
    bus.ack = 1'b0;
    cyc(2);
    check("idle ack valid", bus.valid, 0);
    check("idle ack busy", bus.busy, 0);

    // single short press
    s0 = n_short;
    l0 = n_long;
    expect_char(10'b00_00_00_00_01, 3'd1, 1'b0);
    press(12, 0);
    wait_valid("single short valid", 200);
    check("single short pulses", n_short - s0, 1);
    check("single long pulses", n_long - l0, 0);
    check("single busy in done", bus.busy, 0);
    do_ack("single ack valid");
    check("morse kept after ack", bus.morse, 10'b00_00_00_00_01);
    check("nsym kept after ack", bus.nsym, 1);
    cyc(10);

    // long then short
    s0 = n_short;
    l0 = n_long;
    expect_char(10'b00_00_00_01_10, 3'd2, 1'b0);
    press(60, 20);
    press(12, 0);
    wait_valid("long short valid", 200);
    check("long short s pulses", n_short - s0, 1);
    check("long short l pulses", n_long - l0, 1);
    do_ack("long short ack valid");
    cyc(10);

    // six shorts overflow
    s0 = n_short;
    expect_char(10'b01_01_01_01_01, 3'd5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      press(12, 20);
    end
    wait_valid("overflow valid", 200);
    check("overflow pulses", n_short - s0, 6);
    do_ack("overflow ack valid");
    cyc(10);

    // bouncing key never accepted
    s0 = n_short;
    l0 = n_long;
    for (int i = 0; i < 40; i++) begin
      bus.key = ((i / 3) % 2) == 0;
      cyc(1);
    end
    bus.key = 1'b0;
    cyc(60);
    check("bounce short", n_short - s0, 0);
    check("bounce long", n_long - l0, 0);
    check("bounce busy", bus.busy, 0);
    check("bounce valid", bus.valid, 0);

    // presses while valid are ignored
    expect_char(10'b00_00_00_00_01, 3'd1, 1'b0);
    press(12, 0);
    wait_valid("hold valid", 200);
    s0 = n_short;
    l0 = n_long;
    press(60, 60);
    check("done valid held", bus.valid, 1);
    check("done morse held", bus.morse, 10'b00_00_00_00_01);
    check("done nsym held", bus.nsym, 1);
    check("done no short", n_short - s0, 0);
    check("done no long", n_long - l0, 0);
    do_ack("done ack valid");
    expect_char(10'b00_00_00_00_10, 3'd1, 1'b0);
    press(60, 0);
    wait_valid("fresh after ack valid", 200);
    do_ack("fresh ack valid");
    cyc(10);

    // key held across ack does not start a capture
    expect_char(10'b00_00_00_00_01, 3'd1, 1'b0);
    press(12, 0);
    wait_valid("held ack valid", 200);
    bus.key = 1'b1;
    cyc(20);
    do_ack("held ack clear");
    cyc(40);
    check("held no busy", bus.busy, 0);
    bus.key = 1'b0;
    cyc(20);
    check("held release busy", bus.busy, 0);

    // reset mid-press
    press(12, 20);
    bus.key = 1'b1;
    cyc(16);
    check("pre reset busy", bus.busy, 1);
    check("pre reset nsym", bus.nsym, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset busy", bus.busy, 0);
    check("async reset nsym", bus.nsym, 0);
    check("async reset morse", bus.morse, 0);
    check("async reset short", bus.short, 0);
    bus.key = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(10);
    expect_char(10'b00_00_00_00_01, 3'd1, 1'b0);
    press(12, 0);
    wait_valid("after reset valid", 200);
    do_ack("after reset ack valid");
    cyc(5);

    check("pending chars", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
